std_gray_ptr_sync: RTL



---
 rtl/std_gray_pkg.sv | 22 ++
 rtl/std_gray2bin.sv | 17 +
 rtl/std_gray_ptr_sync.sv | 95 +++++++++
 3 files changed

// File: rtl/std_gray_pkg.sv
// Shared constants and helpers for the gray-pointer synchroniser.
// The helpers work on a 64-bit container. Callers zero-extend narrower values and truncate the result.
package std_gray_pkg;

  localparam int SYNC_STAGES_MIN = 2;
  localparam int GRAY_MAX_W      = 64;

  // Zero-extension keeps the top gray bit equal to the top binary bit after truncation.
  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [6:0] popcount(input logic [GRAY_MAX_W-1:0] v);
    logic [6:0] n;
    n = '0;
    for (int i = 0; i < GRAY_MAX_W; i++) begin
      n = n + {6'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/std_gray2bin.sv
// Combinational gray-to-binary decode.
// Each binary bit is the XOR of all gray bits at or above it.
module std_gray2bin #(
  parameter int DW = 8
) (
  input  logic [DW-1:0] gray,
  output logic [DW-1:0] bin
);

  always_comb begin
    bin = '0;
    for (int i = 0; i < DW; i++) begin
      bin[i] = ^(gray >> i);
    end
  end

endmodule

// File: rtl/std_gray_ptr_sync.sv
// Receive-side synchroniser for a gray-coded pointer or counter from a foreign clock domain.
// It provides a registered binary decode, a change strobe with a wrap-aware step, and a sticky illegal-step flag.
module std_gray_ptr_sync
  import std_gray_pkg::*;
#(
  parameter int DW          = 8,
  parameter int SYNC_STAGES = 2,
  parameter int CHECK_EN    = 1
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic [DW-1:0] gray_in,
  input  logic          err_clr,
  output logic [DW-1:0] gray_out,
  output logic [DW-1:0] bin_out,
  output logic          change,
  output logic [DW-1:0] delta,
  output logic          err
);

  if (SYNC_STAGES < SYNC_STAGES_MIN) begin : g_bad_stages
    $error("std_gray_ptr_sync: SYNC_STAGES must be at least %0d", SYNC_STAGES_MIN);
  end
  if (DW < 2) begin : g_bad_dw
    $error("std_gray_ptr_sync: DW must be at least 2");
  end

  logic [DW-1:0] sync_q [SYNC_STAGES];
  logic [DW-1:0] g_q;
  logic [DW-1:0] bin_next;
  logic          change_next;

  // Plain flop chain. Nothing may sit between the stages, or metastability settling time is lost.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
    end else begin
      sync_q[0] <= gray_in;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
    end
  end

  assign gray_out = sync_q[SYNC_STAGES-1];

  std_gray2bin #(.DW(DW)) u_gray2bin (
    .gray (gray_out),
    .bin  (bin_next)
  );

  assign change_next = (gray_out != g_q);

  // g_q and bin_out update together, so bin_out always equals the decode of g_q.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      g_q     <= '0;
      bin_out <= '0;
      change  <= 1'b0;
      delta   <= '0;
    end else begin
      g_q     <= gray_out;
      bin_out <= bin_next;
      change  <= change_next;
      delta   <= change_next ? (bin_next - bin_out) : '0;
    end
  end

  if (CHECK_EN != 0) begin : g_chk
    logic err_set;
    logic err_q;

    assign err_set = (popcount(64'(gray_out ^ g_q)) > 7'd1);

    // A new illegal step takes priority over a clear in the same cycle.
    always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
        err_q <= 1'b0;
      end else if (err_set) begin
        err_q <= 1'b1;
      end else if (err_clr) begin
        err_q <= 1'b0;
      end
    end

    assign err = err_q;
  end else begin : g_nochk
    logic err_clr_unused;
    assign err_clr_unused = err_clr;
    assign err            = 1'b0;
  end

endmodule
